load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 23 ++
 rtl/lsu_lane_align.sv | 53 +++++
 rtl/load_store_unit.sv | 162 ++++++++++++++++
 tb/tb_load_store_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access-size encoding, FSM states,
// and the size-to-byte-count helper.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RD_WAIT = 2'b01,
    WRITE   = 2'b10,
    RESP    = 2'b11
  } state_e;

  function automatic logic [3:0] size_bytes(input size_e s);
    return 4'd1 << s;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane extraction with sign/zero extension for loads, and
// byte-lane merge of store data into a read word for sub-word stores.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0]              word_i,
  input  logic [$clog2(XLEN/8)-1:0]    off_i,
  input  size_e                        size_i,
  input  logic                         unsigned_i,
  input  logic [XLEN-1:0]              wdata_i,
  output logic [XLEN-1:0]              load_o,
  output logic [XLEN-1:0]              merge_o
);

  localparam int SH_W = $clog2(XLEN);

  logic [SH_W-1:0] shamt;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] mask;
  logic [XLEN-1:0] lane_mask;
  logic            sbit;

  always_comb begin
    shamt   = {off_i, 3'b000};
    shifted = word_i >> shamt;
    mask    = '1;
    sbit    = shifted[XLEN-1];
    case (size_i)
      SZ_B: begin
        mask = XLEN'(8'hFF);
        sbit = shifted[7];
      end
      SZ_H: begin
        mask = XLEN'(16'hFFFF);
        sbit = shifted[15];
      end
      SZ_W: begin
        mask = XLEN'(32'hFFFF_FFFF);
        sbit = shifted[31];
      end
      default: begin
        mask = '1;
        sbit = shifted[XLEN-1];
      end
    endcase
    load_o    = (shifted & mask) | ((sbit && !unsigned_i) ? ~mask : '0);
    lane_mask = mask << shamt;
    merge_o   = (word_i & ~lane_mask) | ((wdata_i & mask) << shamt);
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: alignment check, aligned memory read,
// read-modify-write for sub-word stores, and a one-cycle response pulse.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int MEM_LAT = 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_store,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_misaligned,
  output logic [XLEN-1:0] mem_raddr,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] mem_waddr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            mem_wr
);

  localparam int NBYTES = XLEN / 8;
  localparam int OFF_W  = $clog2(NBYTES);
  localparam int CNT_W  = $clog2(MEM_LAT + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              store_q, store_d;
  size_e             size_q, size_d;
  logic              uns_q, uns_d;
  logic              mis_q, mis_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   line_q, line_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;

  logic [3:0]        acc_bytes;
  logic [OFF_W-1:0]  acc_mask;
  logic              req_mis;
  logic              req_full;
  logic [XLEN-1:0]   aligned_addr;
  logic [XLEN-1:0]   load_ext;
  logic [XLEN-1:0]   merged;

  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .word_i     (mem_rdata),
    .off_i      (addr_q[OFF_W-1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .load_o     (load_ext),
    .merge_o    (merged)
  );

  always_comb begin
    acc_bytes = size_bytes(size_e'(req_size));
    acc_mask  = OFF_W'(acc_bytes - 4'd1);
    // A double access has no legal alignment on a 32-bit datapath.
    req_mis   = ((req_addr[OFF_W-1:0] & acc_mask) != '0) ||
                (req_size == SZ_D && XLEN == 32);
    req_full  = (acc_bytes == 4'(NBYTES));
    aligned_addr = {addr_q[XLEN-1:OFF_W], {OFF_W{1'b0}}};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    store_d = store_q;
    size_d  = size_q;
    uns_d   = uns_q;
    mis_d   = mis_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    line_d  = line_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          store_d = req_store;
          size_d  = size_e'(req_size);
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          mis_d   = req_mis;
          cnt_d   = '0;
          if (req_mis) begin
            rdata_d = '0;
            state_d = RESP;
          end else if (req_store && req_full) begin
            line_d  = req_wdata;
            state_d = WRITE;
          end else begin
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q == CNT_W'(MEM_LAT - 1)) begin
          if (store_q) begin
            line_d  = merged;
            state_d = WRITE;
          end else begin
            rdata_d = load_ext;
            state_d = RESP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WRITE: begin
        rdata_d = '0;
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      store_q <= 1'b0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      mis_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      line_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      store_q <= store_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      mis_q   <= mis_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      line_q  <= line_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs are gated by RST so they are quiet even in the first reset cycle.
  always_comb begin
    req_ready      = (state_q == IDLE) && !RST;
    rsp_valid      = (state_q == RESP) && !RST;
    rsp_misaligned = rsp_valid && mis_q;
    rsp_rdata      = RST ? '0 : rdata_q;
    mem_raddr      = ((state_q == RD_WAIT) && !RST) ? aligned_addr : '0;
    mem_wr         = (state_q == WRITE) && !RST;
    mem_waddr      = mem_wr ? aligned_addr : '0;
    mem_wdata      = mem_wr ? line_q : '0;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized bench for load_store_unit (XLEN=64, MEM_LAT=1)
// against a byte-level reference model and a small word-array memory.
module tb_load_store_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_misaligned;
  logic [63:0] mem_raddr;
  logic [63:0] mem_rdata;
  logic [63:0] mem_waddr;
  logic [63:0] mem_wdata;
  logic        mem_wr;

  logic [63:0] mem [32];
  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  assign mem_rdata = mem[mem_raddr[7:3]];

  load_store_unit #(.XLEN(64), .MEM_LAT(1)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_store      (req_store),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_misaligned (rsp_misaligned),
    .mem_raddr      (mem_raddr),
    .mem_rdata      (mem_rdata),
    .mem_waddr      (mem_waddr),
    .mem_wdata      (mem_wdata),
    .mem_wr         (mem_wr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request and compare the whole transaction with the model.
  task automatic do_req(input logic st, input logic [1:0] sz, input logic un,
                        input logic [63:0] ad, input logic [63:0] wd);
    int          n, lane, exp_lat, exp_wr_cyc, exp_nwr;
    int          rsp_cyc, wr_cyc, nwr;
    logic        exp_mis, reads;
    logic [63:0] old, val, nw, exp_rdata, exp_waddr;
    logic [63:0] got_rdata, got_waddr, got_wdata;
    logic        got_mis;

    n          = 1 << sz;
    lane       = int'(ad % 8);
    old        = mem[ad[7:3]];
    exp_mis    = (ad % n) != 0;
    exp_rdata  = '0;
    exp_waddr  = ad & ~64'd7;
    nw         = old;
    exp_nwr    = 0;
    exp_wr_cyc = -1;
    reads      = 1'b0;
    if (exp_mis) begin
      exp_lat = 1;
    end else if (!st) begin
      val = '0;
      for (int i = 0; i < n; i++) val[8*i +: 8] = old[8*(lane+i) +: 8];
      if (!un && val[8*n-1])
        for (int i = n; i < 8; i++) val[8*i +: 8] = 8'hFF;
      exp_rdata = val;
      exp_lat   = 2;
      reads     = 1'b1;
    end else begin
      for (int i = 0; i < n; i++) nw[8*(lane+i) +: 8] = wd[8*i +: 8];
      exp_nwr = 1;
      if (n == 8) begin
        exp_wr_cyc = 1;
        exp_lat    = 2;
      end else begin
        exp_wr_cyc = 2;
        exp_lat    = 3;
        reads      = 1'b1;
      end
    end

    @(negedge CLK);
    chk("ready", 64'(req_ready), 64'd1);
    req_valid    = 1'b1;
    req_store    = st;
    req_size     = sz;
    req_unsigned = un;
    req_addr     = ad;
    req_wdata    = wd;
    @(posedge CLK);
    #1 req_valid = 1'b0;

    rsp_cyc = -1; wr_cyc = -1; nwr = 0;
    got_rdata = '0; got_waddr = '0; got_wdata = '0; got_mis = 1'b0;
    for (int c = 1; c <= 8 && rsp_cyc < 0; c++) begin
      @(negedge CLK);
      if (c == 1 && reads) chk("raddr", mem_raddr, exp_waddr);
      if (mem_wr) begin
        nwr++;
        wr_cyc    = c;
        got_waddr = mem_waddr;
        got_wdata = mem_wdata;
        mem[mem_waddr[7:3]] = mem_wdata;
      end
      if (rsp_valid) begin
        rsp_cyc   = c;
        got_rdata = rsp_rdata;
        got_mis   = rsp_misaligned;
      end
    end
    chk("rsp_cycle", 64'(rsp_cyc), 64'(exp_lat));
    chk("rsp_misaligned", 64'(got_mis), 64'(exp_mis));
    chk("rsp_rdata", got_rdata, exp_rdata);
    chk("wr_count", 64'(nwr), 64'(exp_nwr));
    if (exp_nwr == 1) begin
      chk("wr_cycle", 64'(wr_cyc), 64'(exp_wr_cyc));
      chk("waddr", got_waddr, exp_waddr);
      chk("wdata", got_wdata, nw);
    end
    if (rsp_cyc >= 0) begin
      @(negedge CLK);
      chk("rsp_pulse", 64'(rsp_valid), 64'd0);
      chk("rdata_hold", rsp_rdata, exp_rdata);
    end
  endtask

  initial begin
    int wr_seen, rsp_seen;
    RST = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 32; i++) mem[i] = {$urandom, $urandom};
    mem[0] = 64'hDEADBEEF_00000000;
    mem[1] = 64'h11223344_55667788;
    mem[2] = 64'h00000000_80000000;

    repeat (2) @(negedge CLK);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_misaligned", 64'(rsp_misaligned), 64'd0);
    chk("rst_mem_wr", 64'(mem_wr), 64'd0);
    chk("rst_rdata", rsp_rdata, 64'd0);
    chk("rst_raddr", mem_raddr, 64'd0);
    chk("rst_waddr", mem_waddr, 64'd0);
    chk("rst_wdata", mem_wdata, 64'd0);
    RST = 1'b0;

    do_req(1'b0, 2'b00, 1'b0, 64'h13, 64'h0);
    do_req(1'b1, 2'b01, 1'b0, 64'h0A, 64'hBEEF);
    chk("sh_mem", mem[1], 64'h11223344_BEEF7788);
    do_req(1'b1, 2'b10, 1'b0, 64'h06, 64'h12345678);
    do_req(1'b1, 2'b11, 1'b0, 64'h10, 64'hCAFEF00D_01234567);
    do_req(1'b0, 2'b10, 1'b1, 64'h04, 64'h0);
    do_req(1'b0, 2'b10, 1'b0, 64'h04, 64'h0);
    do_req(1'b0, 2'b11, 1'b0, 64'h0C, 64'h0);

    for (int k = 0; k < 60; k++)
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 64'($urandom_range(0, 255)),
             {$urandom, $urandom});

    // Reset in the middle of a read-modify-write byte store.
    @(negedge CLK);
    chk("rmw_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_store = 1'b1; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 64'h21; req_wdata = 64'hA5;
    @(posedge CLK);
    #1 req_valid = 1'b0;
    @(negedge CLK);
    chk("rmw_raddr", mem_raddr, 64'h20);
    RST = 1'b1;
    @(negedge CLK);
    chk("midrst_ready", 64'(req_ready), 64'd0);
    chk("midrst_mem_wr", 64'(mem_wr), 64'd0);
    chk("midrst_rsp", 64'(rsp_valid), 64'd0);
    RST = 1'b0;
    wr_seen = 0; rsp_seen = 0;
    @(negedge CLK);
    chk("postrst_ready", 64'(req_ready), 64'd1);
    for (int c = 0; c < 5; c++) begin
      if (mem_wr) wr_seen++;
      if (rsp_valid) rsp_seen++;
      @(negedge CLK);
    end
    chk("abandon_wr", 64'(wr_seen), 64'd0);
    chk("abandon_rsp", 64'(rsp_seen), 64'd0);

    do_req(1'b0, 2'b11, 1'b0, 64'h20, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
